led_matrix_scan: RTL and testbench

Drives an 8×8 LED matrix from the 64-bit life grid the evolution FSM produces on `display`. It is the consumer end of that interface. A new grid is accepted through a valid/ready handshake into a pending buffer. Each full scan draws the active grid one row at a time, with a dwell period and an anti-ghosting blank period per row. Pending grids swap in only at scan boundaries, so no frame ever tears.

---
 rtl/led_pkg.sv | 20 ++
 rtl/dwell_counter.sv | 32 +++
 rtl/led_matrix_scan.sv | 154 +++++++++++++++
 tb/tb_led_matrix_scan.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, grid constants and row extraction for the LED matrix scanner
package led_pkg;

    localparam int GRID_W     = 8;
    localparam int GRID_CELLS = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRIVE,
        ST_BLANK
    } scan_state_t;

    // Column bits of row r; bit 8*r+c of the grid is row r, column c.
    function automatic logic [GRID_W-1:0] row_slice(input logic [GRID_CELLS-1:0] grid,
                                                    input logic [2:0]            r);
        return grid[GRID_W*r +: GRID_W];
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - loadable down counter timing the DRIVE and BLANK phases
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture load_value this cycle (takes priority over counting)
//   load_value  : terminal count minus one for the phase being entered
//   value       : current count
//   zero        : value has reached zero (last cycle of the phase)
module dwell_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - double-buffered 8x8 LED matrix row scanner
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   enable       : scan enable
//   frame        : 64-bit grid, bit 8*r+c = row r, column c
//   frame_valid  : frame offered by producer
//   frame_ready  : pending buffer empty; transfer on valid & ready at posedge
//   row_sel      : one-hot active-high row drive (registered)
//   col_data     : active-high column drive for the selected row (registered)
//   scan_done    : one-cycle pulse at the end of each full scan (registered)
module led_matrix_scan
    import led_pkg::*;
#(
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [GRID_CELLS-1:0] frame,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic [GRID_W-1:0]     row_sel,
    output logic [GRID_W-1:0]     col_data,
    output logic                  scan_done
);

    localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);

    scan_state_t           state;
    logic [2:0]            row;
    logic [2:0]            row_nx;
    logic [GRID_CELLS-1:0] pending_buf;
    logic [GRID_CELLS-1:0] active_buf;
    logic                  pending_full;
    logic                  active_valid;
    logic                  take;

    logic                  cnt_load;
    logic [CW-1:0]         cnt_load_value;
    logic [CW-1:0]         cnt_value;
    logic                  cnt_zero;

    assign frame_ready = !pending_full;
    assign take        = frame_valid && !pending_full;
    assign row_nx      = row + 3'd1;

    dwell_counter #(.W(CW)) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    // The counter is reloaded on every entry into DRIVE or BLANK, so each
    // phase always lasts its full length regardless of where it was left.
    always_comb begin
        cnt_load       = 1'b0;
        cnt_load_value = DWELL_LD;
        case (state)
            ST_LOAD:  cnt_load = 1'b1;
            ST_DRIVE: begin
                if (!enable || cnt_zero) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = BLANK_LD;
                end
            end
            ST_BLANK: begin
                if (cnt_zero && enable && row != 3'd7) begin
                    cnt_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs are assigned alongside the state transition so they always
    // reflect the state being entered, with no input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            row          <= 3'd0;
            pending_buf  <= '0;
            active_buf   <= '0;
            pending_full <= 1'b0;
            active_valid <= 1'b0;
            row_sel      <= '0;
            col_data     <= '0;
            scan_done    <= 1'b0;
        end else begin
            scan_done <= 1'b0;

            // A transfer needs pending empty and the LOAD swap needs it full,
            // so the two updates of pending_full never collide.
            if (take) begin
                pending_buf  <= frame;
                pending_full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    row      <= 3'd0;
                    row_sel  <= '0;
                    col_data <= '0;
                    if (enable && (pending_full || active_valid)) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (pending_full) begin
                        active_buf   <= pending_buf;
                        pending_full <= 1'b0;
                        active_valid <= 1'b1;
                    end
                    row      <= 3'd0;
                    state    <= ST_DRIVE;
                    row_sel  <= 8'h01;
                    col_data <= row_slice(pending_full ? pending_buf : active_buf, 3'd0);
                end
                ST_DRIVE: begin
                    if (!enable || cnt_zero) begin
                        state    <= ST_BLANK;
                        row_sel  <= '0;
                        col_data <= '0;
                    end
                end
                ST_BLANK: begin
                    if (cnt_value == '0) begin
                        if (!enable) begin
                            state <= ST_IDLE;
                            row   <= 3'd0;
                        end else if (row != 3'd7) begin
                            row      <= row_nx;
                            state    <= ST_DRIVE;
                            row_sel  <= 8'h01 << row_nx;
                            col_data <= row_slice(active_buf, row_nx);
                        end else begin
                            scan_done <= 1'b1;
                            state     <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb/tb_led_matrix_scan.sv - scoreboard bench for led_matrix_scan with DWELL=4, BLANK=2
module tb_led_matrix_scan;

    localparam int DWELL  = 4;
    localparam int BLANK  = 2;
    localparam int PERIOD = 1 + 8 * (DWELL + BLANK);

    logic        clk;
    logic        reset;
    logic        enable;
    logic [63:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        scan_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] exp_q[$];
    bit          mon_en      = 0;
    bit          allow_short = 0;
    logic [7:0]  prev_sel    = 8'h00;
    int          run_len     = 0;
    int          gap_len     = 0;

    led_matrix_scan #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .scan_done   (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected {row_sel, col_data} of each row of one scan of grid g.
    task automatic push_scan(input logic [63:0] g);
        for (int r = 0; r < 8; r++) begin
            logic [7:0] sel;
            sel = 8'h01 << r;
            exp_q.push_back({sel, g[8*r +: 8]});
        end
    endtask

    task automatic wait_done(output int c);
        int n;
        n = 0;
        c = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done && n < 300);
        if (scan_done) c = cyc;
        else check_eq("scan_done_timeout", scan_done, 1);
    endtask

    task automatic wait_row(input logic [7:0] sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (row_sel !== sel && n < 300);
        if (row_sel !== sel) check_eq("row_wait_timeout", row_sel, sel);
    endtask

    // Row monitor: each row start pops the scoreboard, dwell and inter-row
    // blank lengths are measured from the output waveform.
    always @(negedge clk) begin
        if (mon_en) begin
            if (row_sel != 8'h00) begin
                if (prev_sel == 8'h00) begin
                    if (exp_q.size() == 0) begin
                        check_eq("row_unexpected", {row_sel, col_data}, 16'h0000);
                    end else begin
                        check_eq("row_data", {row_sel, col_data}, exp_q.pop_front());
                    end
                    if (row_sel != 8'h01) check_eq("blank_len", gap_len, BLANK);
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end else begin
                if (prev_sel != 8'h00) begin
                    if (!allow_short) check_eq("dwell_len", run_len, DWELL);
                    allow_short = 0;
                    gap_len = 1;
                end else begin
                    gap_len++;
                end
            end
            prev_sel = row_sel;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int load_cyc, c1, c2, c3, nz;
        logic [63:0] f1, f2, fa, fb, f5, f6;
        f1 = 64'h0000_0000_0000_00FF;
        f2 = 64'h8040_2010_0804_0201;
        fa = 64'hA5A5_A5A5_A5A5_A5A5;
        fb = 64'h3C3C_3C3C_3C3C_3C3C;
        f5 = 64'h1234_5678_9ABC_DEF0;
        f6 = 64'h0F0F_F0F0_5555_AAAA;

        reset = 1'b1; enable = 1'b0; frame = '0; frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_row_sel", row_sel, 8'h00);
        check_eq("reset_col_data", col_data, 8'h00);
        check_eq("reset_scan_done", scan_done, 0);
        check_eq("reset_frame_ready", frame_ready, 1);
        reset = 1'b0;
        mon_en = 1;

        // Basic scan, first-row latency and scan period.
        push_scan(f1);
        enable = 1'b1; frame = f1; frame_valid = 1'b1;
        @(negedge clk);
        check_eq("t1_ready_low", frame_ready, 0);
        check_eq("t1_no_row_yet", row_sel, 8'h00);
        frame_valid = 1'b0;
        @(negedge clk);
        load_cyc = cyc;
        check_eq("t1_ready_in_load", frame_ready, 0);
        check_eq("t1_blank_in_load", row_sel, 8'h00);
        @(negedge clk);
        check_eq("t1_row0_sel", row_sel, 8'h01);
        check_eq("t1_row0_col", col_data, 8'hFF);
        check_eq("t1_ready_back", frame_ready, 1);

        // Bit-mapping frame queued during scan 1.
        push_scan(f2);
        frame = f2; frame_valid = 1'b1;
        @(negedge clk);
        check_eq("t2_accept", frame_ready, 0);
        frame_valid = 1'b0;
        wait_done(c1);
        check_eq("t1_period", c1 - load_cyc, PERIOD);

        // Double buffering: accept during row 2, stall a third frame.
        wait_row(8'h04);
        push_scan(fa);
        push_scan(fb);
        frame = fa; frame_valid = 1'b1;
        @(negedge clk);
        check_eq("t3_accept_low", frame_ready, 0);
        frame = fb;
        nz = 0;
        do begin
            @(negedge clk);
            nz++;
        end while (!frame_ready && nz < 300);
        check_eq("t3_release_row0", row_sel, 8'h01);
        check_eq("t3_release_col", col_data, 8'hA5);
        @(negedge clk);
        check_eq("t3_third_accept", frame_ready, 0);
        frame_valid = 1'b0;
        wait_done(c1);

        // Enable drop in row 3 of the 3C scan.
        wait_row(8'h08);
        allow_short = 1;
        enable = 1'b0;
        @(negedge clk);
        check_eq("t4_blank_sel", row_sel, 8'h00);
        check_eq("t4_blank_col", col_data, 8'h00);
        exp_q.delete();
        nz = 0;
        repeat (6) begin
            @(negedge clk);
            if (row_sel != 8'h00 || scan_done) nz++;
        end
        check_eq("t4_idle_quiet", nz, 0);
        push_scan(fb);
        enable = 1'b1;
        @(negedge clk);
        check_eq("t4_load_blank", row_sel, 8'h00);
        @(negedge clk);
        check_eq("t4_redraw_sel", row_sel, 8'h01);
        check_eq("t4_redraw_col", col_data, 8'h3C);

        // Repeat scans without new data.
        push_scan(fb); push_scan(fb); push_scan(fb);
        wait_done(c1);
        wait_done(c2);
        wait_done(c3);
        check_eq("t6_period_a", c2 - c1, PERIOD);
        check_eq("t6_period_b", c3 - c2, PERIOD);

        // Reset in row 5 with a pending frame.
        wait_row(8'h20);
        frame = f5; frame_valid = 1'b1;
        @(negedge clk);
        check_eq("t5_pending", frame_ready, 0);
        frame_valid = 1'b0;
        allow_short = 1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_sel", row_sel, 8'h00);
        check_eq("t5_rst_col", col_data, 8'h00);
        check_eq("t5_rst_ready", frame_ready, 1);
        check_eq("t5_rst_done", scan_done, 0);
        reset = 1'b0;
        exp_q.delete();
        nz = 0;
        repeat (20) begin
            @(negedge clk);
            if (row_sel != 8'h00 || scan_done) nz++;
        end
        check_eq("t5_no_scan", nz, 0);
        push_scan(f6);
        frame = f6; frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_load_blank", row_sel, 8'h00);
        @(negedge clk);
        check_eq("t5_new_row0_sel", row_sel, 8'h01);
        check_eq("t5_new_row0_col", col_data, 8'hAA);
        wait_done(c1);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
